// File: rtl/ex_muldiv_hilo.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply, restoring divide; WIDTH step cycles plus one sign-fix/commit cycle.
module ex_muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [1:0]           op_reg, op_next;
  logic                 sign_a_reg, sign_a_next;
  logic                 sign_b_reg, sign_b_next;
  logic                 dbz_pend_reg, dbz_pend_next;
  logic [WIDTH-1:0]     opd_reg, opd_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;
  logic                 done_reg, done_next;
  logic                 dbz_reg, dbz_next;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_acc;
  logic                 signed_op, neg_res;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand magnitudes and one radix-2 step of each engine.
  always_comb begin
    abs_a = (!op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b = (!op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opd_reg} : {(WIDTH+1){1'b0}});
    mul_acc = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opd_reg};
    div_ge    = !div_diff[WIDTH];
    div_acc   = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};

    signed_op = !op_reg[0];
    neg_res   = signed_op && (sign_a_reg ^ sign_b_reg);
    prod_fix  = neg_res ? -acc_reg : acc_reg;
    quo_fix   = neg_res ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix   = (signed_op && sign_a_reg) ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_next       = op_reg;
    sign_a_next   = sign_a_reg;
    sign_b_next   = sign_b_reg;
    dbz_pend_next = dbz_pend_reg;
    opd_next      = opd_reg;
    acc_next      = acc_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;
    dbz_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (wr_hi) hi_next = wdata;
        if (wr_lo) lo_next = wdata;
        if (start && !flush) begin
          op_next     = op;
          sign_a_next = src_a[WIDTH-1];
          sign_b_next = src_b[WIDTH-1];
          cnt_next    = '0;
          if (op[1] && (src_b == '0)) begin
            dbz_pend_next = 1'b1;
            state_next    = FIN;
          end else begin
            dbz_pend_next = 1'b0;
            state_next    = RUN;
            if (op[1]) begin
              acc_next = {{WIDTH{1'b0}}, abs_a};
              opd_next = abs_b;
            end else begin
              acc_next = {{WIDTH{1'b0}}, abs_b};
              opd_next = abs_a;
            end
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          acc_next = op_reg[1] ? div_acc : mul_acc;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH-1)) state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
        if (!flush) begin
          done_next = 1'b1;
          if (dbz_pend_reg) begin
            dbz_next = 1'b1;
          end else if (op_reg[1]) begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end else begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      dbz_pend_reg <= 1'b0;
      opd_reg      <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      dbz_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      sign_a_reg   <= sign_a_next;
      sign_b_reg   <= sign_b_next;
      dbz_pend_reg <= dbz_pend_next;
      opd_reg      <= opd_next;
      acc_reg      <= acc_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
      dbz_reg      <= dbz_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign dbz  = dbz_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Directed bench for ex_muldiv_hilo: expected results queued at start, checked on done.
module tb_ex_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        wr_hi, wr_lo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ex_muldiv_hilo #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. wr_at > 0 pulses an MTLO of 0xAA at that busy cycle
  // and then confirms lo still holds lo_hold.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int elat, input int wr_at, input logic [31:0] lo_hold);
    exp_t e, got_e;
    int   n;
    int   busy_cnt;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.lat = elat;
    sb.push_back(e);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    n = 0;
    for (int k = 1; k <= 100 && n == 0; k++) begin
      if (wr_at > 0 && k == wr_at) begin
        wr_lo = 1'b1; wdata = 32'h0000_00AA;
      end
      @(negedge clk);
      if (wr_at > 0 && k == wr_at) begin
        wr_lo = 1'b0;
        chk({tag, " lo_ignored"}, lo, lo_hold);
      end
      if (done) n = k;
      else if (busy) busy_cnt++;
    end
    got_e = sb.pop_front();
    chk({tag, " latency"}, n, got_e.lat);
    chk({tag, " busy_cycles"}, busy_cnt, got_e.lat);
    chk({tag, " hi"}, hi, got_e.hi);
    chk({tag, " lo"}, lo, got_e.lo);
    chk({tag, " dbz"}, {31'd0, dbz}, {31'd0, got_e.dbz});
    $display("[TB] %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b done_at=%0d",
             tag, a, b, hi, lo, dbz, n);
  endtask

  initial begin
    int dcount;
    rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0; flush = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("MULT -3*5",      2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 0, 0);
    run_op("MULTU max*max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 0, 0);
    run_op("DIVU 100/7",     2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33, 0, 0);
    run_op("DIV -7/2",       2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0, 0);
    run_op("DIV ovf",        2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33, 0, 0);
    run_op("DIV 7/-2",       2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33, 0, 0);

    wr_hi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("MTHI", hi, 32'h0000_1234);
    chk("MTLO", lo, 32'h0000_5678);
    $display("[TB] MTHI/MTLO -> hi=0x%08h lo=0x%08h", hi, lo);

    run_op("DIVU 9/0", 2'b11, 32'd9, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b1, 1, 0, 0);

    // Flush in RUN: no commit, no done.
    start = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("flush no_done", dcount, 32'd0);
    chk("flush hi", hi, 32'h0000_1234);
    chk("flush lo", lo, 32'h0000_5678);
    $display("[TB] flush MULT 6*7 -> busy=%0b done_pulses=%0d hi=0x%08h lo=0x%08h", busy, dcount, hi, lo);

    // Flush in IDLE drops a coincident start.
    start = 1'b1; flush = 1'b1; op = 2'b01;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle flush busy", {31'd0, busy}, 32'd0);
    $display("[TB] start+flush in idle -> busy=%0b", busy);

    run_op("MULT 6*7 wr_lo busy", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 5, 32'h0000_5678);

    // Asynchronous reset mid-RUN.
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst hi", hi, 32'd0);
    chk("async rst lo", lo, 32'd0);
    $display("[TB] reset mid-RUN -> busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("MULTU 3*4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_hilo.md
Name: ex_muldiv_hilo

Overview:
- Execute-stage consumer of the ID/EX pipeline register. Runs the integer multiply/divide instructions MULT, MULTU, DIV and DIVU.
- Owns the architectural HI/LO registers and serves MTHI/MTLO writes and the HI/LO reads used by MFHI/MFLO.
- Iterative radix-2 engine. `busy` drives the hazard unit, which holds PC, IF/ID and ID/EX (enable low) while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, width of the step counter; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request, driven from the ID/EX HI/LO-write enable decoded as a mul/div op.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  WIDTH  RD1 from ID/EX, after forwarding (multiplicand or dividend).
- src_b  input  WIDTH  RD2 from ID/EX, after forwarding (multiplier or divisor).
- wr_hi  input  1  MTHI write strobe.
- wr_lo  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- flush  input  1  abort the in-flight operation (exception/syscall).
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse when the result is committed or a divide-by-zero is reported.
- dbz  output  1  divide-by-zero flag, valid while `done` is high.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, counter = 0.
  - hi = 0, lo = 0, busy = 0, done = 0, dbz = 0.
  - All internal accumulators are cleared.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE, start = 1, on the clock edge:
  - Latch op and the sign bits of src_a and src_b.
  - For signed ops (op[0] = 0), latch absolute values; for unsigned ops, latch raw values.
  - Set counter = 0 and go to RUN.
- IDLE, start = 0: remain in IDLE.
- RUN:
  - Each cycle performs one step: shift-add for multiply, restoring shift-subtract for divide.
  - counter increments each cycle.
  - After the step with counter = WIDTH-1, go to FIN. RUN therefore lasts exactly WIDTH cycles.
- FIN (one cycle), sign correction:
  - MULT: negate the 2*WIDTH-bit product if sign_a ^ sign_b.
  - DIV: negate the quotient if sign_a ^ sign_b; the remainder takes the sign of the dividend.
  - Write {hi, lo} = {upper product, lower product} for multiply, or {remainder, quotient} for divide.
  - done = 1 for this cycle only; return to IDLE.
- Latency: with start sampled at edge 0, busy is high from edge 0 through edge WIDTH+1 (WIDTH+1 cycles). hi/lo are updated at edge WIDTH+1 (33 for WIDTH = 32).
- Divide by zero (src_b = 0 on a DIV or DIVU start):
  - Skip RUN and go IDLE -> FIN.
  - In FIN: dbz = 1, done = 1, hi and lo left unchanged.
  - busy lasts 1 cycle.
- Signed overflow, 0x80000000 / 0xFFFFFFFF (DIV): result lo = 0x80000000, hi = 0. No trap.
- MTHI/MTLO:
  - wr_hi/wr_lo take effect at the clock edge only when state = IDLE; while busy they are ignored.
  - wr_hi and wr_lo may be asserted together.
  - start together with a write in IDLE: the write is applied this edge; the later result overwrites it in FIN.
- start while busy: ignored; the pipeline guarantees it does not occur.
- flush:
  - In RUN or FIN: state returns to IDLE at the next edge; hi, lo, done and dbz are untouched (no commit).
  - In IDLE: any coincident start is dropped.
- Reset mid-operation: immediate return to IDLE with all reset values; no partial commit.
- hi and lo are registered outputs only; they never show intermediate results.

Test Plan:
- Reset, then MULT src_a = 0xFFFFFFFD (-3), src_b = 5 -> busy high 33 cycles, done at edge 33, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. DIVU 100 / 7 -> lo = 14, hi = 2.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- MTHI 0x1234, MTLO 0x5678 in IDLE, then DIVU 9 / 0 -> done = 1 and dbz = 1 one cycle after start; hi = 0x1234, lo = 0x5678 unchanged.
- Start MULT 6 * 7, assert flush at RUN cycle 10 -> IDLE next edge, no done, hi/lo keep prior values. Then wr_lo = 1 with wdata = 0xAA while busy on a new op -> ignored.
- Start DIVU, pull rst low mid-RUN -> busy = 0 and hi = lo = 0 immediately (asynchronously); after release a new MULTU 3 * 4 gives lo = 12.
